// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: serialises one DATA_BITS payload per handshake as
// start bit, LSB-first data and one or two stop bits, paced by baud_clk_in
// rising edges (OVERSAMPLING of them per bit period).
module uart_tx_sequencer #(
  parameter int unsigned OVERSAMPLING = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  input  logic                 baud_clk_in,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_valid_in,
  output logic                 tx_ready_out,
  output logic                 tx_out,
  output logic                 busy_out
);

  localparam int unsigned TCW   = $clog2(OVERSAMPLING) + 1;
  localparam int unsigned BCW   = $clog2(DATA_BITS) + 1;
  localparam int unsigned NSTOP = (STOP_BITS == 2) ? 2 : 1;

  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLING - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(NSTOP - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q,    state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;
  logic                 ready_q,    ready_d;
  logic                 baud_q;
  logic                 armed_q;
  logic                 tick;
  logic                 bit_end;

  // armed_q keeps a level already high at reset release from counting as an edge
  assign tick    = baud_clk_in & ~baud_q & armed_q;
  assign bit_end = tick && (tick_cnt_q == TICK_LAST);

  assign tx_out       = tx_q;
  assign busy_out     = busy_q;
  assign tx_ready_out = ready_q;

  // Baud edge detector: delayed copy of baud_clk_in plus post-reset arm flag
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      baud_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      baud_q  <= baud_clk_in;
      armed_q <= 1'b1;
    end
  end

  // Sequencer state, counters, shift register and registered outputs
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic; tx_d is set one bit ahead so tx_out is purely registered
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;

    if (state_q != IDLE && tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tx_valid_in && ready_q) begin
          state_d    = START;
          shift_d    = tx_data_in;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = STOP;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
